pwm_duty_sequencer: RTL and testbench

- Controller that sequences three center-aligned PWM phase channels for the motor drive.
- Accepts duty commands from the control loop over a valid/ready handshake and clamps them to legal limits.
- Applies duty only at PWM period boundaries, slew-limited per period.
- Owns the PWM channels' reset line: arming, disable and latched-fault shutdown.

---
 rtl/pwm_duty_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sequencer.sv
// Three-phase center-aligned PWM duty sequencer: clamps and slews duty
// commands at period boundaries, and owns PWM arming, disable and fault reset.
//
// Ports:
//   i_clk, i_reset_n          clock, async active-low reset
//   i_enable                  level, request drive running
//   i_fault                   level, gate-driver fault
//   i_fault_clear             pulse, leave FAULT (needs fault=0, enable=0)
//   i_period_tick             pulse, PWM channel A valley
//   i_cmd_valid, o_cmd_ready  duty command handshake
//   i_cmd_duty_[abc]          commanded duty per phase
//   o_duty_[abc]              duty to each PWM channel
//   o_pwm_reset_n             active-low reset to the PWM channels
//   o_state                   0 DISABLED, 1 ARMING, 2 RUN, 3 FAULT
//   o_fault_latched           1 while in FAULT
//   o_at_target               1 in RUN when all duties equal their targets
module pwm_duty_sequencer #(
    parameter int WIDTH       = 12,
    parameter int MAX_STEP    = 16,
    parameter int DUTY_MIN    = 31,
    parameter int DUTY_MAX    = 4065,
    parameter int ARM_PERIODS = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_fault,
    input  logic             i_fault_clear,
    input  logic             i_period_tick,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [WIDTH-1:0] i_cmd_duty_a,
    input  logic [WIDTH-1:0] i_cmd_duty_b,
    input  logic [WIDTH-1:0] i_cmd_duty_c,
    output logic [WIDTH-1:0] o_duty_a,
    output logic [WIDTH-1:0] o_duty_b,
    output logic [WIDTH-1:0] o_duty_c,
    output logic             o_pwm_reset_n,
    output logic [1:0]       o_state,
    output logic             o_fault_latched,
    output logic             o_at_target
);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMING   = 2'd1,
        RUN      = 2'd2,
        FAULT    = 2'd3
    } state_t;

    localparam int AW = $clog2(ARM_PERIODS + 1);

    localparam logic [WIDTH-1:0]  MID      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]  DMIN     = WIDTH'(DUTY_MIN);
    localparam logic [WIDTH-1:0]  DMAX     = WIDTH'(DUTY_MAX);
    localparam logic [WIDTH-1:0]  STEP_U   = WIDTH'(MAX_STEP);
    localparam logic signed [WIDTH:0] STEP_S = (WIDTH+1)'(MAX_STEP);
    localparam logic [AW-1:0]     ARM_LAST = AW'(ARM_PERIODS);

    state_t           state, state_n;
    logic [WIDTH-1:0] duty_a, duty_b, duty_c;
    logic [WIDTH-1:0] duty_a_n, duty_b_n, duty_c_n;
    logic [WIDTH-1:0] tgt_a, tgt_b, tgt_c;
    logic [WIDTH-1:0] tgt_a_n, tgt_b_n, tgt_c_n;
    logic [AW-1:0]    arm_cnt, arm_cnt_n;
    logic             pwm_rst_n, pwm_rst_n_n;
    logic             cmd_rdy, cmd_rdy_n;
    logic             flt, flt_n;
    logic             at_tgt, at_tgt_n;
    logic             accept;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
        if (v < DMIN)      return DMIN;
        else if (v > DMAX) return DMAX;
        else               return v;
    endfunction

    // Difference taken one bit wider and signed so it can never wrap.
    function automatic logic [WIDTH-1:0] step_toward(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] tgt
    );
        logic signed [WIDTH:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S)       return cur + STEP_U;
        else if (diff < -STEP_S) return cur - STEP_U;
        else                     return tgt;
    endfunction

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= DISABLED;
            duty_a    <= MID;
            duty_b    <= MID;
            duty_c    <= MID;
            tgt_a     <= MID;
            tgt_b     <= MID;
            tgt_c     <= MID;
            arm_cnt   <= '0;
            pwm_rst_n <= 1'b0;
            cmd_rdy   <= 1'b0;
            flt       <= 1'b0;
            at_tgt    <= 1'b0;
        end else begin
            state     <= state_n;
            duty_a    <= duty_a_n;
            duty_b    <= duty_b_n;
            duty_c    <= duty_c_n;
            tgt_a     <= tgt_a_n;
            tgt_b     <= tgt_b_n;
            tgt_c     <= tgt_c_n;
            arm_cnt   <= arm_cnt_n;
            pwm_rst_n <= pwm_rst_n_n;
            cmd_rdy   <= cmd_rdy_n;
            flt       <= flt_n;
            at_tgt    <= at_tgt_n;
        end
    end

    always_comb begin
        state_n   = state;
        duty_a_n  = duty_a;
        duty_b_n  = duty_b;
        duty_c_n  = duty_c;
        tgt_a_n   = tgt_a;
        tgt_b_n   = tgt_b;
        tgt_c_n   = tgt_c;
        arm_cnt_n = arm_cnt;
        accept    = 1'b0;

        if (i_fault && state != FAULT) begin
            state_n   = FAULT;
            duty_a_n  = MID;
            duty_b_n  = MID;
            duty_c_n  = MID;
            tgt_a_n   = MID;
            tgt_b_n   = MID;
            tgt_c_n   = MID;
            arm_cnt_n = '0;
        end else begin
            unique case (state)
                DISABLED: begin
                    accept = i_cmd_valid & cmd_rdy;
                    if (i_enable) state_n = ARMING;
                end
                ARMING, RUN: begin
                    if (!i_enable) begin
                        state_n   = DISABLED;
                        duty_a_n  = MID;
                        duty_b_n  = MID;
                        duty_c_n  = MID;
                        tgt_a_n   = MID;
                        tgt_b_n   = MID;
                        tgt_c_n   = MID;
                        arm_cnt_n = '0;
                    end else begin
                        accept = i_cmd_valid & cmd_rdy;
                        if (i_period_tick && state == ARMING) begin
                            if (arm_cnt + AW'(1) == ARM_LAST) begin
                                state_n   = RUN;
                                arm_cnt_n = '0;
                            end else begin
                                arm_cnt_n = arm_cnt + AW'(1);
                            end
                        end
                        // Steps use the targets held before this cycle's command.
                        if (i_period_tick && state == RUN) begin
                            duty_a_n = step_toward(duty_a, tgt_a);
                            duty_b_n = step_toward(duty_b, tgt_b);
                            duty_c_n = step_toward(duty_c, tgt_c);
                        end
                    end
                end
                FAULT: begin
                    if (i_fault_clear && !i_fault && !i_enable)
                        state_n = DISABLED;
                end
                default: state_n = DISABLED;
            endcase
        end

        if (accept) begin
            tgt_a_n = clamp(i_cmd_duty_a);
            tgt_b_n = clamp(i_cmd_duty_b);
            tgt_c_n = clamp(i_cmd_duty_c);
        end
    end

    assign pwm_rst_n_n = (state_n == ARMING) || (state_n == RUN);
    assign cmd_rdy_n   = (state_n != FAULT);
    assign flt_n       = (state_n == FAULT);
    assign at_tgt_n    = (state_n == RUN) &&
                         (duty_a_n == tgt_a_n) &&
                         (duty_b_n == tgt_b_n) &&
                         (duty_c_n == tgt_c_n);

    assign o_cmd_ready     = cmd_rdy;
    assign o_duty_a        = duty_a;
    assign o_duty_b        = duty_b;
    assign o_duty_c        = duty_c;
    assign o_pwm_reset_n   = pwm_rst_n;
    assign o_state         = state;
    assign o_fault_latched = flt;
    assign o_at_target     = at_tgt;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: arming, ramps, clamping,
// tick/command overlap, fault latch and async reset.
module tb_pwm_duty_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        fault = 1'b0;
    logic        fault_clear = 1'b0;
    logic        tick = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_a = 12'd0, cmd_b = 12'd0, cmd_c = 12'd0;
    logic [11:0] duty_a, duty_b, duty_c;
    logic        pwm_reset_n;
    logic [1:0]  state;
    logic        fault_latched;
    logic        at_target;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_duty_sequencer dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_enable       (enable),
        .i_fault        (fault),
        .i_fault_clear  (fault_clear),
        .i_period_tick  (tick),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_duty_a   (cmd_a),
        .i_cmd_duty_b   (cmd_b),
        .i_cmd_duty_c   (cmd_c),
        .o_duty_a       (duty_a),
        .o_duty_b       (duty_b),
        .o_duty_c       (duty_c),
        .o_pwm_reset_n  (pwm_reset_n),
        .o_state        (state),
        .o_fault_latched(fault_latched),
        .o_at_target    (at_target)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input int a, input int b, input int c);
        @(negedge clk);
        cmd_a = 12'(a); cmd_b = 12'(b); cmd_c = 12'(c);
        cmd_valid = 1'b1;
        check("ready_at_cmd", 32'(cmd_ready), 1);
        @(negedge clk) cmd_valid = 1'b0;
    endtask

    task automatic arm();
        @(negedge clk) enable = 1'b1;
        @(negedge clk);
        repeat (4) do_tick();
        check("arm_run", 32'(state), 2);
    endtask

    function automatic int mstep(input int cur, input int tgt);
        if (tgt - cur > 16)      return cur + 16;
        else if (cur - tgt > 16) return cur - 16;
        else                     return tgt;
    endfunction

    task automatic chk_duty(input string tag, input int a, input int b, input int c);
        check({tag, "_a"}, 32'(duty_a), a);
        check({tag, "_b"}, 32'(duty_b), b);
        check({tag, "_c"}, 32'(duty_c), c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ea, eb, ec;
        bit inr;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_pwm", 32'(pwm_reset_n), 0);
        check("rst_ready", 32'(cmd_ready), 0);
        check("rst_flt", 32'(fault_latched), 0);
        check("rst_at", 32'(at_target), 0);
        chk_duty("rst", 2048, 2048, 2048);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("dis_ready", 32'(cmd_ready), 1);

        // 1: arming
        enable = 1'b1;
        @(negedge clk);
        check("arm_state", 32'(state), 1);
        check("arm_pwm", 32'(pwm_reset_n), 1);
        for (int i = 1; i <= 3; i++) begin
            do_tick();
            check("arm_hold", 32'(state), 1);
            chk_duty("arm", 2048, 2048, 2048);
        end
        do_tick();
        check("run_state", 32'(state), 2);
        chk_duty("run0", 2048, 2048, 2048);
        check("run_at0", 32'(at_target), 1);

        // 2: ramp
        send(2148, 2048, 1900);
        check("ramp_at_drop", 32'(at_target), 0);
        chk_duty("nostep", 2048, 2048, 2048);
        for (int k = 1; k <= 10; k++) begin
            do_tick();
            chk_duty("ramp",
                     (2048 + 16*k < 2148) ? 2048 + 16*k : 2148,
                     2048,
                     (2048 - 16*k > 1900) ? 2048 - 16*k : 1900);
            check("ramp_at", 32'(at_target), (k == 10) ? 1 : 0);
        end

        // 3: clamping
        send(0, 4095, 31);
        ea = 2148; eb = 2048; ec = 1900;
        inr = 1'b1;
        for (int k = 1; k <= 135; k++) begin
            do_tick();
            ea = mstep(ea, 31); eb = mstep(eb, 4065); ec = mstep(ec, 31);
            if (duty_a < 31 || duty_b > 4065 || duty_c < 31) inr = 1'b0;
            if (k == 126) check("clamp_b126", 32'(duty_b), 4064);
            if (k == 127) check("clamp_b127", 32'(duty_b), 4065);
            if (k == 64)  chk_duty("clamp64", ea, eb, ec);
        end
        check("clamp_range", 32'(inr), 1);
        chk_duty("clamp_end", 31, 4065, 31);
        check("clamp_at", 32'(at_target), 1);

        // 4: command and tick together
        @(negedge clk);
        cmd_a = 12'd1000; cmd_b = 12'd4065; cmd_c = 12'd31;
        cmd_valid = 1'b1; tick = 1'b1;
        check("ovl_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0; tick = 1'b0;
        check("ovl_old", 32'(duty_a), 31);
        check("ovl_ready2", 32'(cmd_ready), 1);
        do_tick();
        check("ovl_new", 32'(duty_a), 47);
        do_tick();
        check("ovl_new2", 32'(duty_a), 63);

        // 5: fault wins over tick and command
        @(negedge clk);
        fault = 1'b1; tick = 1'b1; cmd_valid = 1'b1;
        cmd_a = 12'd3000;
        @(negedge clk);
        fault = 1'b0; tick = 1'b0; cmd_valid = 1'b0;
        check("flt_state", 32'(state), 3);
        check("flt_pwm", 32'(pwm_reset_n), 0);
        check("flt_ready", 32'(cmd_ready), 0);
        check("flt_latch", 32'(fault_latched), 1);
        chk_duty("flt", 2048, 2048, 2048);
        @(negedge clk) fault_clear = 1'b1;
        @(negedge clk) fault_clear = 1'b0;
        check("flt_clr_en", 32'(state), 3);
        enable = 1'b0;
        @(negedge clk) fault_clear = 1'b1;
        @(negedge clk) fault_clear = 1'b0;
        check("flt_clr", 32'(state), 0);
        check("flt_clr_latch", 32'(fault_latched), 0);
        check("flt_clr_ready", 32'(cmd_ready), 1);

        // 6: async reset mid-RUN
        arm();
        send(2200, 2048, 2048);
        do_tick();
        do_tick();
        check("pre_rst_a", 32'(duty_a), 2080);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 0);
        check("arst_pwm", 32'(pwm_reset_n), 0);
        check("arst_ready", 32'(cmd_ready), 0);
        chk_duty("arst", 2048, 2048, 2048);
        enable = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // disable in RUN resets targets
        arm();
        send(2500, 1500, 2048);
        do_tick();
        chk_duty("pre_dis", 2064, 2032, 2048);
        @(negedge clk) enable = 1'b0;
        @(negedge clk);
        check("dis_state", 32'(state), 0);
        check("dis_pwm", 32'(pwm_reset_n), 0);
        chk_duty("dis", 2048, 2048, 2048);
        arm();
        check("rearm_at", 32'(at_target), 1);
        do_tick();
        chk_duty("rearm", 2048, 2048, 2048);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
